// File: rtl/bomberman_pkg.sv
// Arena geometry, bomb FSM state encoding and tile helpers shared by the bomb logic.
// BOMB_RANGE2_EN widens the explosion cross from 5 to 9 cells.
package bomberman_pkg;

  localparam int ARENA_COLS = 33;
  localparam int ARENA_ROWS = 27;
  localparam int TILE_SHIFT = 4;

`ifdef BOMB_RANGE2_EN
  localparam int CROSS_CELLS = 9;
`else
  localparam int CROSS_CELLS = 5;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FUSE    = 2'd1,
    CLEAR   = 2'd2,
    EXPLODE = 2'd3
  } bomb_state_t;

  // Indestructible pillars sit on every odd column of every odd row.
  function automatic logic is_pillar(input logic [5:0] col, input logic [5:0] row);
    return col[0] & row[0];
  endfunction

  function automatic logic [9:0] tile_addr(input logic [5:0] col, input logic [5:0] row);
    return ({4'b0000, row} << 5) + {4'b0000, row} + {4'b0000, col};
  endfunction

endpackage

// File: rtl/bomb_cell_iter.sv
// Resolves one cell of the explosion cross: its tile, block-map address and whether
// it may be cleared. BOMB_RANGE2_EN adds the four distance-2 cells (indices 5..8).
module bomb_cell_iter
  import bomberman_pkg::*;
(
  input  logic [5:0] ctr_col,
  input  logic [5:0] ctr_row,
  input  logic [3:0] cell_idx,
  output logic       cell_valid,
  output logic [9:0] cell_addr,
  output logic [5:0] cell_col,
  output logic [5:0] cell_row
);

  localparam logic signed [7:0] MAX_COL = 8'(ARENA_COLS - 1);
  localparam logic signed [7:0] MAX_ROW = 8'(ARENA_ROWS - 1);

  logic signed [7:0] dx;
  logic signed [7:0] dy;
  logic              in_set;
  logic              far;
  logic signed [7:0] col_s;
  logic signed [7:0] row_s;
  logic              in_range;
  logic              blocked;

  // Order: centre, up1, down1, left1, right1, up2, down2, left2, right2.
  always_comb begin
    dx     = 8'sd0;
    dy     = 8'sd0;
    in_set = 1'b1;
    far    = 1'b0;
    case (cell_idx)
      4'd0: ;
      4'd1: dy = -8'sd1;
      4'd2: dy = 8'sd1;
      4'd3: dx = -8'sd1;
      4'd4: dx = 8'sd1;
`ifdef BOMB_RANGE2_EN
      4'd5: begin dy = -8'sd2; far = 1'b1; end
      4'd6: begin dy = 8'sd2;  far = 1'b1; end
      4'd7: begin dx = -8'sd2; far = 1'b1; end
      4'd8: begin dx = 8'sd2;  far = 1'b1; end
`endif
      default: in_set = 1'b0;
    endcase
  end

  // Offsets are applied in signed arithmetic so underflow shows up as a sign bit.
  assign col_s    = $signed({2'b00, ctr_col}) + dx;
  assign row_s    = $signed({2'b00, ctr_row}) + dy;
  assign in_range = !col_s[7] && (col_s <= MAX_COL) && !row_s[7] && (row_s <= MAX_ROW);
  assign cell_col = col_s[5:0];
  assign cell_row = row_s[5:0];

`ifdef BOMB_RANGE2_EN
  logic [5:0] nb_col;
  logic [5:0] nb_row;
  // The flame stops at a pillar, so a distance-2 cell needs a clear distance-1 neighbour.
  assign nb_col  = ctr_col + 6'(dx >>> 1);
  assign nb_row  = ctr_row + 6'(dy >>> 1);
  assign blocked = far && is_pillar(nb_col, nb_row);
`else
  assign blocked = far;
`endif

  assign cell_valid = in_set && in_range && !is_pillar(cell_col, cell_row) && !blocked;
  assign cell_addr  = tile_addr(cell_col, cell_row);

endmodule

// File: rtl/bomb_sequencer.sv
// Single-bomb lifecycle: place, fuse countdown, block-map clearing, explosion window.
// BOMB_RANGE2_EN extends the cross to range 2 (9 cells).
module bomb_sequencer
  import bomberman_pkg::*;
#(
  parameter int FUSE_TICKS = 180,
  parameter int EXP_TICKS  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        place_req,
  input  logic [9:0]  bm_x,
  input  logic [9:0]  bm_y,
  input  logic        blk_ack,
  output logic        bomb_active,
  output logic [9:0]  bomb_x,
  output logic [9:0]  bomb_y,
  output logic        exp_active,
  output logic        post_exp_active,
  output logic        bm_hit,
  output logic        blk_we,
  output logic [9:0]  blk_addr,
  output bomb_state_t state_dbg
);

  localparam logic [7:0] LAST_FUSE = 8'(FUSE_TICKS - 1);
  localparam logic [7:0] LAST_EXP  = 8'(EXP_TICKS - 1);
  localparam logic [3:0] LAST_IDX  = 4'(CROSS_CELLS - 1);

  bomb_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [5:0]  ctr_col_q, ctr_col_d;
  logic [5:0]  ctr_row_q, ctr_row_d;
  logic        post_q, post_d;
  logic        hit_q, hit_d;

  logic [5:0]  p_col;
  logic [5:0]  p_row;
  logic        c_valid [CROSS_CELLS];
  logic [9:0]  c_addr  [CROSS_CELLS];
  logic [5:0]  c_col   [CROSS_CELLS];
  logic [5:0]  c_row   [CROSS_CELLS];
  logic        cur_valid;
  logic [9:0]  cur_addr;
  logic        hit_any;
  logic        advance;

  // Tile under the player's centre point.
  assign p_col = 6'((bm_x + 10'd8) >> TILE_SHIFT);
  assign p_row = 6'((bm_y + 10'd8) >> TILE_SHIFT);

  // One resolver per cross cell: the clear walk selects one, the hit test ORs all.
  for (genvar g = 0; g < CROSS_CELLS; g++) begin : g_cell
    bomb_cell_iter u_cell (
      .ctr_col    (ctr_col_q),
      .ctr_row    (ctr_row_q),
      .cell_idx   (4'(g)),
      .cell_valid (c_valid[g]),
      .cell_addr  (c_addr[g]),
      .cell_col   (c_col[g]),
      .cell_row   (c_row[g])
    );
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_addr  = 10'd0;
    hit_any   = 1'b0;
    for (int i = 0; i < CROSS_CELLS; i++) begin
      if (idx_q == 4'(i)) begin
        cur_valid = c_valid[i];
        cur_addr  = c_addr[i];
      end
      if (c_valid[i] && (c_col[i] == p_col) && (c_row[i] == p_row)) hit_any = 1'b1;
    end
  end

  // Block-map port: blk_we holds with a stable blk_addr until blk_ack in the same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ctr_col_d   = ctr_col_q;
    ctr_row_d   = ctr_row_q;
    post_d      = 1'b0;
    advance     = 1'b0;
    bomb_active = 1'b0;
    exp_active  = 1'b0;
    blk_we      = 1'b0;
    blk_addr    = 10'd0;
    case (state_q)
      IDLE: begin
        if (place_req) begin
          ctr_col_d = p_col;
          ctr_row_d = p_row;
          cnt_d     = 8'd0;
          state_d   = FUSE;
        end
      end
      FUSE: begin
        bomb_active = 1'b1;
        if (frame_tick) begin
          if (cnt_q == LAST_FUSE) begin
            cnt_d   = 8'd0;
            idx_d   = 4'd0;
            state_d = CLEAR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      CLEAR: begin
        exp_active = 1'b1;
        if (cur_valid) begin
          blk_we   = 1'b1;
          blk_addr = cur_addr;
          advance  = blk_ack;
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = 8'd0;
            state_d = EXPLODE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      EXPLODE: begin
        exp_active = 1'b1;
        if (frame_tick) begin
          if (cnt_q == LAST_EXP) begin
            cnt_d   = 8'd0;
            post_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    hit_d = exp_active && hit_any;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= 4'd0;
      ctr_col_q <= 6'd0;
      ctr_row_q <= 6'd0;
      post_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ctr_col_q <= ctr_col_d;
      ctr_row_q <= ctr_row_d;
      post_q    <= post_d;
      hit_q     <= hit_d;
    end
  end

  assign bomb_x          = {ctr_col_q, 4'b0000};
  assign bomb_y          = {ctr_row_q, 4'b0000};
  assign post_exp_active = post_q;
  assign bm_hit          = hit_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Bench for bomb_sequencer: directed scenarios plus random traffic against a
// queue-based model of the bomb lifecycle.
module tb_bomb_sequencer;
  import bomberman_pkg::*;

  localparam int FUSE = 3;
  localparam int EXP  = 2;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        place_req;
  logic [9:0]  bm_x;
  logic [9:0]  bm_y;
  logic        blk_ack;
  logic        bomb_active;
  logic [9:0]  bomb_x;
  logic [9:0]  bomb_y;
  logic        exp_active;
  logic        post_exp_active;
  logic        bm_hit;
  logic        blk_we;
  logic [9:0]  blk_addr;
  bomb_state_t state_dbg;

  bomb_sequencer #(.FUSE_TICKS(FUSE), .EXP_TICKS(EXP)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .place_req       (place_req),
    .bm_x            (bm_x),
    .bm_y            (bm_y),
    .blk_ack         (blk_ack),
    .bomb_active     (bomb_active),
    .bomb_x          (bomb_x),
    .bomb_y          (bomb_y),
    .exp_active      (exp_active),
    .post_exp_active (post_exp_active),
    .bm_hit          (bm_hit),
    .blk_we          (blk_we),
    .blk_addr        (blk_addr),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;
  int ack_mode = 0;
  int clr_cycles = 0;
  logic [9:0] addr_log[$];
  logic [9:0] exp_q[$];

`ifdef BOMB_RANGE2_EN
  localparam int RANGE = 2;
`else
  localparam int RANGE = 1;
`endif
  localparam int NCELLS = 1 + 4 * RANGE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_bomb;
  int m_fuse_cnt;
  int m_cells[$];
  bit m_exp;
  int m_exp_cnt;
  bit m_post;
  bit m_hit;
  int m_col;
  int m_row;
  int m_plan[$];
  int m_hcol[$];
  int m_hrow[$];

  function automatic int tile_of(input int p);
    return ((p + 8) >> 4) & 63;
  endfunction

  function automatic bit pillar(input int c, input int r);
    return ((c & 1) == 1) && ((r & 1) == 1);
  endfunction

  task automatic add_cell(input int c, input int r, input bit blocked);
    bit ok;
    ok = (c >= 0) && (c < 33) && (r >= 0) && (r < 27) && !pillar(c, r) && !blocked;
    m_plan.push_back(ok ? r * 33 + c : -1);
    if (ok) begin
      m_hcol.push_back(c);
      m_hrow.push_back(r);
    end
  endtask

  task automatic build_plan(input int c, input int r);
    int dc[4] = '{0, 0, -1, 1};
    int dr[4] = '{-1, 1, 0, 0};
    m_plan.delete();
    m_hcol.delete();
    m_hrow.delete();
    add_cell(c, r, 0);
    for (int rng = 1; rng <= RANGE; rng++)
      for (int d = 0; d < 4; d++)
        add_cell(c + dc[d] * rng, r + dr[d] * rng,
                 (rng == 2) && pillar(c + dc[d], r + dr[d]));
  endtask

  function automatic bit e_exp();
    return (m_cells.size() > 0) || m_exp;
  endfunction

  function automatic bit e_we();
    return (m_cells.size() > 0) && (m_cells[0] >= 0);
  endfunction

  task automatic model_step();
    bit exp_now;
    bit in_cross;
    int pc;
    int pr;
    exp_now  = e_exp();
    pc       = tile_of(int'(bm_x));
    pr       = tile_of(int'(bm_y));
    in_cross = 0;
    foreach (m_hcol[i]) if (m_hcol[i] == pc && m_hrow[i] == pr) in_cross = 1;
    if (!rst) begin
      m_bomb = 0; m_exp = 0; m_post = 0; m_hit = 0;
      m_col = 0; m_row = 0; m_fuse_cnt = 0; m_exp_cnt = 0;
      m_cells.delete();
      return;
    end
    m_hit  = exp_now && in_cross;
    m_post = 0;
    if (m_bomb) begin
      if (frame_tick) begin
        m_fuse_cnt++;
        if (m_fuse_cnt == FUSE) begin
          m_bomb  = 0;
          m_cells = m_plan;
        end
      end
    end else if (m_cells.size() > 0) begin
      if (m_cells[0] < 0 || blk_ack) begin
        void'(m_cells.pop_front());
        if (m_cells.size() == 0) begin
          m_exp     = 1;
          m_exp_cnt = 0;
        end
      end
    end else if (m_exp) begin
      if (frame_tick) begin
        m_exp_cnt++;
        if (m_exp_cnt == EXP) begin
          m_exp  = 0;
          m_post = 1;
        end
      end
    end else if (place_req) begin
      m_col      = tile_of(int'(bm_x));
      m_row      = tile_of(int'(bm_y));
      m_bomb     = 1;
      m_fuse_cnt = 0;
      build_plan(m_col, m_row);
    end
  endtask

  initial begin
    m_bomb = 0; m_exp = 0; m_post = 0; m_hit = 0; m_col = 0; m_row = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (blk_we === 1'b1 && blk_ack === 1'b1) addr_log.push_back(blk_addr);
    if (state_dbg == CLEAR) clr_cycles++;
    if (chk_on) begin
      chk("bomb_active", 32'(bomb_active), 32'(m_bomb));
      chk("bomb_x", 32'(bomb_x), 32'(m_col * 16));
      chk("bomb_y", 32'(bomb_y), 32'(m_row * 16));
      chk("exp_active", 32'(exp_active), 32'(e_exp()));
      chk("post_exp_active", 32'(post_exp_active), 32'(m_post));
      chk("bm_hit", 32'(bm_hit), 32'(m_hit));
      chk("blk_we", 32'(blk_we), 32'(e_we()));
      chk("blk_addr", 32'(blk_addr), e_we() ? 32'(m_cells[0]) : 32'd0);
    end
  end

  // ---------------- block-map responder ----------------
  initial begin
    int wcnt;
    wcnt    = 0;
    blk_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: blk_ack = 1'b1;
        1: begin
          if (blk_we) begin
            if (wcnt == 3) begin blk_ack = 1'b1; wcnt = 0; end
            else begin blk_ack = 1'b0; wcnt++; end
          end else begin
            blk_ack = 1'b0;
            wcnt    = 0;
          end
        end
        2: blk_ack = 1'b0;
        default: blk_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit pr, input bit ft);
    place_req  = pr;
    frame_tick = ft;
    @(posedge clk);
    #1;
    place_req  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic run_to_clear(input int x, input int y);
    bm_x = 10'(x);
    bm_y = 10'(y);
    pulse(1, 0);
    repeat (FUSE - 1) pulse(0, 1);
    addr_log.delete();
    clr_cycles = 0;
    pulse(0, 1);
  endtask

  task automatic wait_clear(input int budget);
    int n;
    n = 0;
    while (m_cells.size() > 0 && n < budget) begin
      idle(1);
      n++;
    end
    chk("clear_done_state", 32'(state_dbg), 32'(EXPLODE));
  endtask

  task automatic finish_exp();
    repeat (EXP) pulse(0, 1);
    idle(1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(addr_log.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < addr_log.size()) chk({name, "_addr"}, 32'(addr_log[i]), 32'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; frame_tick = 1'b0; place_req = 1'b0; bm_x = '0; bm_y = '0;
    @(posedge clk);
    #1;
    chk_on = 1;
    chk("rst_bomb_active", 32'(bomb_active), 0);
    chk("rst_exp_active", 32'(exp_active), 0);
    chk("rst_blk_we", 32'(blk_we), 0);
    chk("rst_blk_addr", 32'(blk_addr), 0);
    chk("rst_bomb_xy", {bomb_x, bomb_y}, 0);
    chk("rst_post_hit", {post_exp_active, bm_hit}, 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    idle(1);

    // Nominal bomb at (100,60), tile (6,4).
    bm_x = 10'd100; bm_y = 10'd60;
    pulse(1, 0);
    chk("t1_bomb_active", 32'(bomb_active), 1);
    chk("t1_bomb_x", 32'(bomb_x), 96);
    chk("t1_bomb_y", 32'(bomb_y), 64);
    pulse(0, 1); idle(2); pulse(0, 1); idle(1);
    chk("t1_fuse_hold", 32'(bomb_active), 1);
    addr_log.delete();
    clr_cycles = 0;
    pulse(0, 1);
    chk("t1_det_exp", 32'(exp_active), 1);
    chk("t1_det_bomb", 32'(bomb_active), 0);
    chk("t1_det_we", 32'(blk_we), 1);
    chk("t1_det_addr", 32'(blk_addr), 138);
    wait_clear(100);
    exp_q = '{10'd138, 10'd105, 10'd171, 10'd137, 10'd139};
    if (RANGE == 2) begin
      exp_q.push_back(10'd72); exp_q.push_back(10'd204);
      exp_q.push_back(10'd136); exp_q.push_back(10'd140);
    end
    check_log("t1_log");
    chk("t1_clear_len", 32'(clr_cycles), NCELLS);
    bm_x = 10'd112; bm_y = 10'd64;
    idle(1);
    chk("hit_right1", 32'(bm_hit), 1);
    bm_x = 10'd300; bm_y = 10'd300;
    idle(1);
    chk("hit_cleared", 32'(bm_hit), 0);
    pulse(0, 1);
    chk("t1_post_early", 32'(post_exp_active), 0);
    chk("t1_exp_mid", 32'(exp_active), 1);
    pulse(0, 1);
    chk("t1_post", 32'(post_exp_active), 1);
    chk("t1_exp_end", 32'(exp_active), 0);
    chk("t1_idle", 32'(state_dbg), 32'(IDLE));
    pulse(1, 0);
    chk("t1_replace", 32'(bomb_active), 1);
    chk("t1_post_once", 32'(post_exp_active), 0);
    repeat (FUSE) pulse(0, 1);
    wait_clear(100);
    finish_exp();

    // Corner bomb (0,0).
    run_to_clear(0, 0);
    wait_clear(100);
    exp_q = '{10'd0, 10'd33, 10'd1};
    if (RANGE == 2) begin exp_q.push_back(10'd66); exp_q.push_back(10'd2); end
    check_log("corner_log");
    chk("corner_clear_len", 32'(clr_cycles), NCELLS);
    finish_exp();

    // Centre (1,2): pillars above and below.
    run_to_clear(16, 32);
    wait_clear(100);
    exp_q = '{10'd67, 10'd66, 10'd68};
    if (RANGE == 2) exp_q.push_back(10'd69);
    check_log("pillar_log");
    finish_exp();

    // Slow acknowledge and a second place request during the fuse.
    ack_mode = 1;
    bm_x = 10'd100; bm_y = 10'd60;
    pulse(1, 0);
    idle(1);
    bm_x = 10'd200; bm_y = 10'd100;
    pulse(1, 0);
    chk("second_place_x", 32'(bomb_x), 96);
    chk("second_place_y", 32'(bomb_y), 64);
    repeat (FUSE - 1) pulse(0, 1);
    addr_log.delete();
    pulse(0, 1);
    wait_clear(200);
    exp_q = '{10'd138, 10'd105, 10'd171, 10'd137, 10'd139};
    if (RANGE == 2) begin
      exp_q.push_back(10'd72); exp_q.push_back(10'd204);
      exp_q.push_back(10'd136); exp_q.push_back(10'd140);
    end
    check_log("slow_ack_log");
    finish_exp();

    // Reset while a write is pending.
    ack_mode = 2;
    run_to_clear(100, 60);
    idle(2);
    chk("rst_mid_we_before", 32'(blk_we), 1);
    rst = 1'b0;
    idle(1);
    chk("rst_mid_we", 32'(blk_we), 0);
    chk("rst_mid_addr", 32'(blk_addr), 0);
    chk("rst_mid_exp", 32'(exp_active), 0);
    chk("rst_mid_bomb", 32'(bomb_active), 0);
    chk("rst_mid_xy", {bomb_x, bomb_y}, 0);
    rst = 1'b1;
    ack_mode = 0;
    bm_x = 10'd40; bm_y = 10'd40;
    pulse(1, 0);
    chk("rst_mid_replace", 32'(bomb_active), 1);
    chk("rst_mid_replace_x", 32'(bomb_x), 48);
    repeat (FUSE) pulse(0, 1);
    wait_clear(100);
    finish_exp();

    // Random traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) ack_mode = (cyc / 250) % 3 == 2 ? 3 : (cyc / 250) % 3;
      rst        = ($urandom_range(0, 299) != 0);
      place_req  = ($urandom_range(0, 7) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bm_x = 10'($urandom_range(0, 560));
        bm_y = 10'($urandom_range(0, 460));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1; place_req = 1'b0; frame_tick = 1'b0;
    idle(2);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bomb_sequencer.md
# bomb_sequencer

Controller for the single-bomb lifecycle in the Bomberman arena. Accepts a place request from the keyboard path, snaps the bomb to the player's tile, and counts the fuse in frame ticks. It then sequences destruction writes into the block map via a request/acknowledge port, and holds the explosion window. Sits between the PS/2 command decode, the bomberman position registers, the block map module and the pixel-priority mux.

## Interface
Parameters:
- FUSE_TICKS, 180, frames from placement to detonation (1..255)
- EXP_TICKS, 30, frames the explosion stays visible after clearing (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- place_req  in  1  one-cycle bomb-key pulse
- bm_x, bm_y  in  10 each  bomberman top-left, arena coordinates (pixels)
- blk_ack  in  1  block map accepted the current write
- bomb_active  out  1  bomb sprite visible (fuse running)
- bomb_x, bomb_y  out  10 each  bomb tile origin, arena pixels (tile×16)
- exp_active  out  1  explosion visible
- post_exp_active  out  1  one-cycle pulse when explosion ends
- bm_hit  out  1  player inside explosion cross
- blk_we  out  1  block-map clear request
- blk_addr  out  10  map address, row×33+col

## Operation
- Arena grid: 33 columns × 27 rows, 16-px tiles.
- Pillar cells: col odd AND row odd. Map addresses 0..890.
- Player tile: col = (bm_x+8)>>4, row = (bm_y+8)>>4.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including bomb_x/bomb_y and blk_addr.
  - Fuse and explosion counters are 0.
- States:
  - IDLE: place_req latches the player tile into bomb_x/bomb_y, clears the frame counter, and moves to FUSE. place_req is ignored in every other state.
  - FUSE: counts frame_tick. On the FUSE_TICKS-th tick, moves to CLEAR.
  - CLEAR: walks the cross cells in order: centre, up1, down1, left1, right1 (then up2, down2, left2, right2 when configured).
    - A cell is skipped (one cycle, no request) if it lies outside 0..32/0..26 or is a pillar.
    - Otherwise blk_we=1 with blk_addr stable until blk_ack=1.
    - After the last cell, clears the counter and moves to EXPLODE.
  - EXPLODE: counts frame_tick. On the EXP_TICKS-th tick, pulses post_exp_active and moves to IDLE.
- Output levels by state:
  - bomb_active = 1 in FUSE only.
  - exp_active = 1 in CLEAR and EXPLODE.
- bm_hit is registered. It is 1 while exp_active and the current player tile equals any in-range cross cell, pillars excluded.
- Arithmetic:
  - Tile coordinates are 6 bits; cross offsets are signed. Underflow below 0 is detected before the address is formed.
  - Address is computed as (row<<5)+row+col in 10 bits.
- Boundaries:
  - place_req and frame_tick in the same IDLE cycle: placement is accepted, and that tick is not counted.
  - frame_tick during CLEAR is ignored.
  - blk_ack without blk_we is ignored.
  - rst low mid-operation: returns to IDLE next edge, and blk_we drops even if unacknowledged.
  - Bomb at arena corner (0,0): up/left cells are skipped, and only 3 requests are issued.

## Timing
- place_req at cycle N → bomb_active=1 and bomb_x/bomb_y valid at N+1.
- FUSE_TICKS-th frame_tick at cycle M → CLEAR at M+1: exp_active=1, bomb_active=0. The first blk_we is at M+1 if the centre cell is valid.
- Write handshake:
  - A transfer completes in the cycle blk_we & blk_ack.
  - The next cell is evaluated at +1.
  - blk_ack may be combinational from the block map.
  - With a tied-high ack, CLEAR lasts exactly 5 cycles (9 with range 2), skips included.
- EXP_TICKS-th tick in EXPLODE at cycle K:
  - post_exp_active=1 at K+1 only.
  - exp_active=0 and state is IDLE at K+1.
  - A new place_req is accepted at K+1.
- bm_hit lags bm_x/bm_y by one cycle.

## Configuration
- BOMB_RANGE2_EN defined: the cross extends 2 tiles per direction (9 cells).
  - A range-2 cell is skipped if its range-1 neighbour in that direction is a pillar. Explosions do not pass pillars.
- Undefined: 5-cell cross, range 1.

## Structure
- Shared package bomberman_pkg holds:
  - ARENA_COLS=33, ARENA_ROWS=27, TILE_SHIFT=4
  - state encoding IDLE/FUSE/CLEAR/EXPLODE
  - the pillar-test function
- Sub-module bomb_cell_iter: takes centre tile and cell index, and returns valid/addr/tile for that cell. It is reused by the bm_hit comparison.

## Test plan
- Place at bm=(100,60), FUSE_TICKS=3, EXP_TICKS=2, ack tied high:
  - bomb tile (6,4), bomb_x/bomb_y=(96,64)
  - detonation on 3rd tick
  - blk_addr sequence 138, 105, 171, 137, 139
  - post_exp_active exactly 2 ticks later
- Bomb at (0,0):
  - requests 0, 33, 1 only
  - CLEAR lasts 5 cycles
- Centre (1,2):
  - up1 (1,1) is a pillar and is skipped
  - with BOMB_RANGE2_EN, up2 (1,0) is also skipped
- Ack delayed 3 cycles per write: blk_addr is held stable, with no duplicate or dropped requests. Second place_req during FUSE is ignored.
- rst low during CLEAR with blk_we=1: all outputs 0 next cycle. Placement works immediately after release.
- Player standing on the right1 cell during EXPLODE: bm_hit=1. Moving out clears it one cycle later.
